// File: rtl/cpu_trace_pkg.sv
// Shared types and constants for the CPU trace line checker.
package cpu_trace_pkg;

    // Parser states, one per field or separator of a trace line.
    typedef enum logic [3:0] {
        IDLE, TIME, PC, COLON, SP1, GRF, ADDR, SP2, EQ, SP3, DATA
    } state_t;

    // Reported line format.
    localparam logic [1:0] FMT_NONE = 2'b00;
    localparam logic [1:0] FMT_REG  = 2'b01;
    localparam logic [1:0] FMT_MEM  = 2'b10;

    // Bit positions inside error_code.
    localparam int ERR_TIME = 0;
    localparam int ERR_PC   = 1;
    localparam int ERR_ADDR = 2;
    localparam int ERR_GRF  = 3;

    // ASCII punctuation used by the trace grammar.
    localparam logic [7:0] CH_CARET  = 8'h5e;
    localparam logic [7:0] CH_AT     = 8'h40;
    localparam logic [7:0] CH_COLON  = 8'h3a;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2a;
    localparam logic [7:0] CH_LT     = 8'h3c;
    localparam logic [7:0] CH_EQ     = 8'h3d;
    localparam logic [7:0] CH_HASH   = 8'h23;
    localparam logic [7:0] CH_SPACE  = 8'h20;

endpackage

// File: rtl/trace_char_class.sv
// Combinational character classifier: decimal digit, lowercase hex digit, nibble value.
module trace_char_class (
    input  logic [7:0] char,
    output logic       is_dec,
    output logic       is_hex,
    output logic [3:0] nibble
);

    // Classify the character and decode its digit value (0 when not a digit).
    always_comb begin
        is_dec = 1'b0;
        is_hex = 1'b0;
        nibble = 4'd0;
        if (char >= 8'h30 && char <= 8'h39) begin
            is_dec = 1'b1;
            is_hex = 1'b1;
            nibble = 4'(char - 8'h30);
        end else if (char >= 8'h61 && char <= 8'h66) begin
            is_hex = 1'b1;
            nibble = 4'(char - 8'h57);
        end
    end

endmodule

// File: rtl/cpu_trace_checker.sv
// Streaming checker for CPU trace lines, one ASCII character per clock.
// Valid/ready note: there is no backpressure; char is consumed every cycle and
// done is a one-cycle valid strobe qualifying format_type and error_code.
module cpu_trace_checker
    import cpu_trace_pkg::*;
#(
    parameter int          TIME_DIGITS = 4,
    parameter int          TIME_W      = 14,
    parameter int          GRF_DIGITS  = 4,
    parameter int          PC_HEX      = 8,
    parameter int          ADDR_HEX    = 8,
    parameter int          DATA_HEX    = 8,
    parameter logic [31:0] PC_LO       = 32'h3000,
    parameter logic [31:0] PC_HI       = 32'h4fff,
    parameter logic [31:0] DM_HI       = 32'h2fff,
    parameter int          GRF_MAX     = 31,
    parameter int          FREQ_W      = 16,
    parameter int          CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        char,
    input  logic [FREQ_W-1:0] freq,
    output logic [1:0]        format_type,
    output logic [3:0]        error_code,
    output logic              done,
    output logic [CNT_W-1:0]  rec_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output state_t            state_dbg
);

    localparam int PC_W   = 4 * PC_HEX;
    localparam int ADDR_W = 4 * ADDR_HEX;
    localparam int GRF_W  = $clog2(10 ** GRF_DIGITS);
    localparam int MOD_W  = (TIME_W > FREQ_W) ? TIME_W : FREQ_W;

    state_t              state;
    logic [TIME_W-1:0]   time_q;
    logic [PC_W-1:0]     pc_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [GRF_W-1:0]    grf_q;
    logic [7:0]          dcnt_q;
    logic [1:0]          fmt_pend;

    logic                is_dec;
    logic                is_hex;
    logic [3:0]          nib;
    logic [3:0]          err_next;
    logic [MOD_W-1:0]    t_ext;
    logic [MOD_W-1:0]    h_ext;

    trace_char_class u_class (
        .char   (char),
        .is_dec (is_dec),
        .is_hex (is_hex),
        .nibble (nib)
    );

    assign state_dbg = state;

    // Semantic error flags for the line currently held in the field registers.
    always_comb begin
        t_ext    = MOD_W'(time_q);
        h_ext    = MOD_W'(freq >> 1);
        err_next = 4'b0000;
        err_next[ERR_TIME] = (h_ext == '0) ? 1'b1 : ((t_ext % h_ext) != '0);
        err_next[ERR_PC]   = (pc_q < PC_W'(PC_LO)) || (pc_q > PC_W'(PC_HI)) || (pc_q[1:0] != 2'b00);
        err_next[ERR_ADDR] = (fmt_pend == FMT_MEM) &&
                             ((addr_q > ADDR_W'(DM_HI)) || (addr_q[1:0] != 2'b00));
        err_next[ERR_GRF]  = (fmt_pend == FMT_REG) && (grf_q > GRF_W'(GRF_MAX));
    end

    // Parser FSM with field capture, registered result strobe and record counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            time_q      <= '0;
            pc_q        <= '0;
            addr_q      <= '0;
            grf_q       <= '0;
            dcnt_q      <= '0;
            fmt_pend    <= FMT_NONE;
            format_type <= FMT_NONE;
            error_code  <= '0;
            done        <= 1'b0;
            rec_cnt     <= '0;
            err_cnt     <= '0;
        end else begin
            format_type <= FMT_NONE;
            error_code  <= '0;
            done        <= 1'b0;
            if (char == CH_CARET) begin
                // A caret always restarts, discarding any partial line.
                state    <= TIME;
                time_q   <= '0;
                pc_q     <= '0;
                addr_q   <= '0;
                grf_q    <= '0;
                dcnt_q   <= '0;
                fmt_pend <= FMT_NONE;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    TIME: begin
                        if (is_dec && dcnt_q < 8'(TIME_DIGITS)) begin
                            time_q <= TIME_W'(time_q * 10 + TIME_W'(nib));
                            dcnt_q <= dcnt_q + 8'd1;
                        end else if (char == CH_AT && dcnt_q != 8'd0) begin
                            state  <= PC;
                            dcnt_q <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    PC: begin
                        // The last PC digit moves on to COLON, which then demands ':'.
                        if (is_hex) begin
                            pc_q   <= {pc_q[PC_W-5:0], nib};
                            dcnt_q <= dcnt_q + 8'd1;
                            if (dcnt_q == 8'(PC_HEX - 1)) state <= COLON;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    COLON: state <= (char == CH_COLON) ? SP1 : IDLE;
                    SP1: begin
                        dcnt_q <= '0;
                        if (char == CH_DOLLAR) begin
                            state    <= GRF;
                            fmt_pend <= FMT_REG;
                        end else if (char == CH_STAR) begin
                            state    <= ADDR;
                            fmt_pend <= FMT_MEM;
                        end else if (char != CH_SPACE) begin
                            state <= IDLE;
                        end
                    end
                    GRF: begin
                        if (is_dec && dcnt_q < 8'(GRF_DIGITS)) begin
                            grf_q  <= GRF_W'(grf_q * 10 + GRF_W'(nib));
                            dcnt_q <= dcnt_q + 8'd1;
                        end else if (char == CH_SPACE && dcnt_q != 8'd0) begin
                            state <= SP2;
                        end else if (char == CH_LT && dcnt_q != 8'd0) begin
                            state <= EQ;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    ADDR: begin
                        if (is_hex && dcnt_q < 8'(ADDR_HEX)) begin
                            addr_q <= {addr_q[ADDR_W-5:0], nib};
                            dcnt_q <= dcnt_q + 8'd1;
                        end else if (char == CH_SPACE && dcnt_q == 8'(ADDR_HEX)) begin
                            state <= SP2;
                        end else if (char == CH_LT && dcnt_q == 8'(ADDR_HEX)) begin
                            state <= EQ;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    SP2: begin
                        if (char == CH_LT)         state <= EQ;
                        else if (char != CH_SPACE) state <= IDLE;
                    end
                    EQ: state <= (char == CH_EQ) ? SP3 : IDLE;
                    SP3: begin
                        if (is_hex) begin
                            state  <= DATA;
                            dcnt_q <= 8'd1;
                        end else if (char != CH_SPACE) begin
                            state <= IDLE;
                        end
                    end
                    DATA: begin
                        if (is_hex && dcnt_q < 8'(DATA_HEX)) begin
                            dcnt_q <= dcnt_q + 8'd1;
                        end else if (char == CH_HASH && dcnt_q == 8'(DATA_HEX)) begin
                            state       <= IDLE;
                            format_type <= fmt_pend;
                            error_code  <= err_next;
                            done        <= 1'b1;
                            if (rec_cnt != '1) rec_cnt <= rec_cnt + CNT_W'(1);
                            if (err_next != 4'b0000 && err_cnt != '1)
                                err_cnt <= err_cnt + CNT_W'(1);
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
